// File: rtl/find_top2_pkg.sv
// find_top2_pkg: shared types and helpers for the find_top2 top-2 scanner.
//   state_t : scanner FSM states (IDLE, SCAN, DONE)
//   clog2   : constant ceiling-log2, used to validate the index width
package find_top2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/find_top2_if.sv
// find_top2_if: request/result bundle between the vote counters, the top-2
// scanner and the reporting logic.
//   master : drives i_start, i_clr, i_cnt (and i_thr), observes results
//   slave  : the scanner; receives requests, drives o_* results
// Optional margin signals exist only when FIND_TOP2_MARGIN_EN is defined.
interface find_top2_if #(
  parameter int unsigned NUM   = 18,
  parameter int unsigned W     = 7,
  parameter int unsigned IDX_W = 5
);
  logic               i_start;
  logic               i_clr;
  logic [NUM*W-1:0]   i_cnt;
  logic               o_busy;
  logic               o_done;
  logic               o_valid;
  logic [W-1:0]       o_max;
  logic [IDX_W-1:0]   o_idx;
  logic [W-1:0]       o_sec;
  logic [IDX_W-1:0]   o_sec_idx;
  logic               o_sec_valid;
`ifdef FIND_TOP2_MARGIN_EN
  logic [W-1:0]       i_thr;
  logic [W-1:0]       o_margin;
  logic               o_ambig;
`endif

  modport master (
`ifdef FIND_TOP2_MARGIN_EN
    output i_thr,
    input  o_margin, o_ambig,
`endif
    output i_start, i_clr, i_cnt,
    input  o_busy, o_done, o_valid, o_max, o_idx, o_sec, o_sec_idx, o_sec_valid
  );

  modport slave (
`ifdef FIND_TOP2_MARGIN_EN
    input  i_thr,
    output o_margin, o_ambig,
`endif
    input  i_start, i_clr, i_cnt,
    output o_busy, o_done, o_valid, o_max, o_idx, o_sec, o_sec_idx, o_sec_valid
  );
endinterface

// File: rtl/top2_update.sv
// top2_update: combinational compare step of the top-2 scan.
//   v, ptr              : current entry value and its index
//   max, idx, sec, sec_idx : running results before this entry
//   nxt_*               : running results after this entry
// Strict '>' keeps the lowest index on ties; an equal later entry lands in sec.
module top2_update #(
  parameter int unsigned W     = 7,
  parameter int unsigned IDX_W = 5
) (
  input  logic [W-1:0]     v,
  input  logic [IDX_W-1:0] ptr,
  input  logic [W-1:0]     max,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     sec,
  input  logic [IDX_W-1:0] sec_idx,
  output logic [W-1:0]     nxt_max,
  output logic [IDX_W-1:0] nxt_idx,
  output logic [W-1:0]     nxt_sec,
  output logic [IDX_W-1:0] nxt_sec_idx
);
  always_comb begin
    nxt_max     = max;
    nxt_idx     = idx;
    nxt_sec     = sec;
    nxt_sec_idx = sec_idx;
    if (v > max) begin
      nxt_sec     = max;
      nxt_sec_idx = idx;
      nxt_max     = v;
      nxt_idx     = ptr;
    end else if (v > sec) begin
      nxt_sec     = v;
      nxt_sec_idx = ptr;
    end
  end
endmodule

// File: rtl/find_top2.sv
// find_top2: snapshots NUM unsigned counts on a start pulse, scans them one
// per cycle and reports the largest and second-largest entries with indices.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : find_top2_if.slave (i_start/i_clr/i_cnt in; o_busy, o_done,
//           o_valid, o_max, o_idx, o_sec, o_sec_idx, o_sec_valid out)
// Macro FIND_TOP2_MARGIN_EN adds i_thr, o_margin (= o_max - o_sec, registered)
// and o_ambig (= o_valid & o_margin < i_thr, combinational).
// Latency: start at edge 0, o_done high after edge NUM+1.
module find_top2
  import find_top2_pkg::*;
#(
  parameter int unsigned NUM   = 18,
  parameter int unsigned W     = 7,
  parameter int unsigned IDX_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  find_top2_if.slave   bus
);

  if (IDX_W < clog2(NUM)) begin : g_idx_w_check
    $error("find_top2: IDX_W too small for NUM");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM - 1);

  state_t           state;
  logic [W-1:0]     snap [NUM];
  logic [IDX_W-1:0] ptr;

  logic [W-1:0]     w_max, w_sec;
  logic [IDX_W-1:0] w_idx, w_sec_idx;
  logic [W-1:0]     n_max, n_sec;
  logic [IDX_W-1:0] n_idx, n_sec_idx;

  logic [W-1:0]     res_max, res_sec;
  logic [IDX_W-1:0] res_idx, res_sec_idx;
  logic             done_q;
`ifdef FIND_TOP2_MARGIN_EN
  logic [W-1:0]     res_margin;
`endif

  top2_update #(.W(W), .IDX_W(IDX_W)) u_update (
    .v           (snap[ptr]),
    .ptr         (ptr),
    .max         (w_max),
    .idx         (w_idx),
    .sec         (w_sec),
    .sec_idx     (w_sec_idx),
    .nxt_max     (n_max),
    .nxt_idx     (n_idx),
    .nxt_sec     (n_sec),
    .nxt_sec_idx (n_sec_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '{default: '0};
      ptr         <= '0;
      w_max       <= '0;
      w_idx       <= '0;
      w_sec       <= '0;
      w_sec_idx   <= '0;
      res_max     <= '0;
      res_idx     <= '0;
      res_sec     <= '0;
      res_sec_idx <= '0;
      done_q      <= 1'b0;
`ifdef FIND_TOP2_MARGIN_EN
      res_margin  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // clr takes priority over a simultaneous start
          if (bus.i_clr) begin
            w_max       <= '0;
            w_idx       <= '0;
            w_sec       <= '0;
            w_sec_idx   <= '0;
            res_max     <= '0;
            res_idx     <= '0;
            res_sec     <= '0;
            res_sec_idx <= '0;
`ifdef FIND_TOP2_MARGIN_EN
            res_margin  <= '0;
`endif
          end else if (bus.i_start) begin
            for (int unsigned k = 0; k < NUM; k++) begin
              snap[k] <= bus.i_cnt[k*W +: W];
            end
            w_max     <= '0;
            w_idx     <= '0;
            w_sec     <= '0;
            w_sec_idx <= '0;
            ptr       <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (bus.i_clr) begin
            w_max       <= '0;
            w_idx       <= '0;
            w_sec       <= '0;
            w_sec_idx   <= '0;
            res_max     <= '0;
            res_idx     <= '0;
            res_sec     <= '0;
            res_sec_idx <= '0;
`ifdef FIND_TOP2_MARGIN_EN
            res_margin  <= '0;
`endif
            ptr         <= '0;
            state       <= IDLE;
          end else begin
            w_max     <= n_max;
            w_idx     <= n_idx;
            w_sec     <= n_sec;
            w_sec_idx <= n_sec_idx;
            if (ptr == LAST) begin
              ptr   <= '0;
              state <= DONE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DONE: begin
          res_max     <= w_max;
          res_idx     <= w_idx;
          res_sec     <= w_sec;
          res_sec_idx <= w_sec_idx;
`ifdef FIND_TOP2_MARGIN_EN
          res_margin  <= w_max - w_sec;
`endif
          done_q      <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_max       = res_max;
  assign bus.o_idx       = res_idx;
  assign bus.o_sec       = res_sec;
  assign bus.o_sec_idx   = res_sec_idx;
  assign bus.o_valid     = (res_max != '0);
  assign bus.o_sec_valid = (res_sec != '0);
`ifdef FIND_TOP2_MARGIN_EN
  assign bus.o_margin    = res_margin;
  assign bus.o_ambig     = (res_max != '0) && (res_margin < bus.i_thr);
`endif

endmodule

// File: tb/tb_find_top2.sv
// tb_find_top2: directed self-checking bench for find_top2 (NUM=18, W=7,
// IDX_W=5). Results are compared as a packed tuple
// {max, idx, sec, sec_idx, valid, sec_valid}.
module tb_find_top2;
  localparam int unsigned NUM   = 18;
  localparam int unsigned W     = 7;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned LAT   = NUM + 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  find_top2_if #(.NUM(NUM), .W(W), .IDX_W(IDX_W)) bus ();

  find_top2 #(.NUM(NUM), .W(W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] results();
    return {bus.o_max, bus.o_idx, bus.o_sec, bus.o_sec_idx, bus.o_valid, bus.o_sec_valid};
  endfunction

  // Starts a scan of v; after scan cycle 3 replaces i_cnt with mid and pulses
  // i_start (both must be ignored). Returns edges from start to o_done, 0 on timeout.
  task automatic run_scan(input logic [NUM*W-1:0] v, input logic [NUM*W-1:0] mid,
                          output int lat);
    bus.i_cnt   = v;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 3) begin
        bus.i_cnt   = mid;
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    bus.i_start = 1'b0;
  endtask

  function automatic logic [NUM*W-1:0] vec_distinct();
    logic [NUM*W-1:0] a;
    a = '0;
    for (int k = 0; k < NUM; k++) a[k*W +: W] = W'(k + 1);
    a[5*W +: W]  = 7'd100;
    a[12*W +: W] = 7'd90;
    return a;
  endfunction

  function automatic logic [NUM*W-1:0] vec_ties();
    logic [NUM*W-1:0] a;
    a = '0;
    a[3*W +: W] = 7'd50;
    a[9*W +: W] = 7'd50;
    return a;
  endfunction

  function automatic logic [NUM*W-1:0] vec_last();
    logic [NUM*W-1:0] a;
    a = '0;
    a[0*W +: W]  = 7'd10;
    a[17*W +: W] = 7'd127;
    return a;
  endfunction

  function automatic logic [NUM*W-1:0] vec_b();
    logic [NUM*W-1:0] a;
    a = '0;
    a[2*W +: W]  = 7'd60;
    a[15*W +: W] = 7'd33;
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.o_busy, bus.o_done, results()} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {bus.o_busy, bus.o_done, results()});
    end
`ifdef FIND_TOP2_MARGIN_EN
    n_checks++;
    if ({bus.o_margin, bus.o_ambig} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_margin: got %h expected 0", {bus.o_margin, bus.o_ambig});
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_distinct();
    int lat;
    logic [NUM*W-1:0] a;
    a = vec_distinct();
    bus.i_cnt   = a;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL distinct_busy: got %b expected 1", bus.o_busy);
    end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.o_done === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL distinct_latency: got %0d expected %0d", lat, LAT);
    end
    n_checks++;
    if (results() !== {7'd100, 5'd5, 7'd90, 5'd12, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL distinct_result: got %h expected %h", results(),
               {7'd100, 5'd5, 7'd90, 5'd12, 1'b1, 1'b1});
    end
`ifdef FIND_TOP2_MARGIN_EN
    n_checks++;
    if ({bus.o_margin, bus.o_ambig} !== {7'd10, 1'b0}) begin
      n_fail++;
      $display("FAIL distinct_margin: got %h expected %h", {bus.o_margin, bus.o_ambig}, {7'd10, 1'b0});
    end
`endif
    // one-cycle done, results hold while inputs wander
    bus.i_cnt = vec_ties();
    tick();
    n_checks++;
    if ({bus.o_done, bus.o_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL distinct_done_pulse: got %b expected 00", {bus.o_done, bus.o_busy});
    end
    repeat (5) tick();
    n_checks++;
    if (results() !== {7'd100, 5'd5, 7'd90, 5'd12, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL distinct_hold: got %h expected %h", results(),
               {7'd100, 5'd5, 7'd90, 5'd12, 1'b1, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    run_scan(vec_last(), vec_last(), lat1);
    n_checks++;
    if (lat1 !== LAT) begin
      n_fail++;
      $display("FAIL last_latency: got %0d expected %0d", lat1, LAT);
    end
    n_checks++;
    if (results() !== {7'd127, 5'd17, 7'd10, 5'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL last_result: got %h expected %h", results(),
               {7'd127, 5'd17, 7'd10, 5'd0, 1'b1, 1'b1});
    end
    // start sampled on the very next edge (NUM+2)
    run_scan(vec_ties(), vec_distinct(), lat2);
    n_checks++;
    if (lat2 !== LAT) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d expected %0d", lat2, LAT);
    end
    n_checks++;
    if (results() !== {7'd50, 5'd3, 7'd50, 5'd9, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ties_result: got %h expected %h", results(),
               {7'd50, 5'd3, 7'd50, 5'd9, 1'b1, 1'b1});
    end
`ifdef FIND_TOP2_MARGIN_EN
    n_checks++;
    if ({bus.o_margin, bus.o_ambig} !== {7'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ties_margin: got %h expected %h", {bus.o_margin, bus.o_ambig}, {7'd0, 1'b1});
    end
`endif
  endtask

  task automatic test_clr_idle();
    int lat;
    int saw;
    tick();
    // start and clr together: clr wins, no scan
    bus.i_cnt   = vec_distinct();
    bus.i_start = 1'b1;
    bus.i_clr   = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_clr   = 1'b0;
    n_checks++;
    if ({bus.o_busy, results()} !== 27'd0) begin
      n_fail++;
      $display("FAIL start_clr_together: got %h expected 0", {bus.o_busy, results()});
    end
    saw = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) saw++;
    end
    n_checks++;
    if (saw !== 0) begin
      n_fail++;
      $display("FAIL start_clr_no_scan: got %0d active cycles expected 0", saw);
    end
    // clr alone clears fresh results
    run_scan(vec_distinct(), vec_distinct(), lat);
    tick();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    n_checks++;
    if ({bus.o_busy, results()} !== 27'd0) begin
      n_fail++;
      $display("FAIL clr_idle: got %h expected 0", {bus.o_busy, results()});
    end
`ifdef FIND_TOP2_MARGIN_EN
    n_checks++;
    if ({bus.o_margin, bus.o_ambig} !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_margin: got %h expected 0", {bus.o_margin, bus.o_ambig});
    end
`endif
  endtask

  task automatic test_zero();
    int lat;
    run_scan('0, '0, lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL zero_done: got latency %0d expected %0d", lat, LAT);
    end
    n_checks++;
    if (results() !== 26'd0) begin
      n_fail++;
      $display("FAIL zero_result: got %h expected 0", results());
    end
  endtask

  task automatic test_abort();
    int lat;
    int saw;
    run_scan(vec_last(), vec_last(), lat);
    tick();
    bus.i_cnt   = vec_distinct();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (3) tick();
    bus.i_cnt = vec_b();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (2) tick();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    n_checks++;
    if ({bus.o_busy, results()} !== 27'd0) begin
      n_fail++;
      $display("FAIL abort_clear: got %h expected 0", {bus.o_busy, results()});
    end
    saw = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (bus.o_done === 1'b1) saw++;
    end
    n_checks++;
    if (saw !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", saw);
    end
    run_scan(vec_b(), vec_distinct(), lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected %0d", lat, LAT);
    end
    n_checks++;
    if (results() !== {7'd60, 5'd2, 7'd33, 5'd15, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_snapshot: got %h expected %h", results(),
               {7'd60, 5'd2, 7'd33, 5'd15, 1'b1, 1'b1});
    end
    saw = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (bus.o_done === 1'b1) saw++;
    end
    n_checks++;
    if (saw !== 0) begin
      n_fail++;
      $display("FAIL start_in_scan_second_done: got %0d pulses expected 0", saw);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [NUM*W-1:0] a;
    bus.i_cnt   = vec_distinct();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_busy, bus.o_done, results()} !== 28'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", {bus.o_busy, bus.o_done, results()});
    end
    #3;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b expected 0", bus.o_busy);
    end
    a = '0;
    a[4*W +: W] = 7'd7;
    run_scan(a, a, lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT);
    end
    n_checks++;
    if (results() !== {7'd7, 5'd4, 7'd0, 5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_result: got %h expected %h", results(),
               {7'd7, 5'd4, 7'd0, 5'd0, 1'b1, 1'b0});
    end
`ifdef FIND_TOP2_MARGIN_EN
    n_checks++;
    if ({bus.o_margin, bus.o_ambig} !== {7'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_margin: got %h expected %h", {bus.o_margin, bus.o_ambig}, {7'd7, 1'b0});
    end
`endif
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_clr   = 1'b0;
    bus.i_cnt   = '0;
`ifdef FIND_TOP2_MARGIN_EN
    bus.i_thr   = 7'd1;
`endif
    test_reset();
    test_distinct();
    test_back_to_back();
    test_clr_idle();
    test_zero();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/find_top2.md
Name: find_top2

Overview:
- Parametrised successor to the single-max histogram scanner.
- Snapshots a packed vector of NUM unsigned counts on a start pulse, scans it sequentially, and reports the largest and second-largest entries with their indices.
- Uses a start/busy/done handshake.
- Sits between the per-class vote counters and the decision/UART reporting logic, where a confidence measure (max vs runner-up) is needed.

Parameters:
- NUM, 18, number of entries in the input vector (2..64).
- W, 7, width of each unsigned count.
- IDX_W, 5, index width; must satisfy 2**IDX_W >= NUM. Elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request; honoured only in IDLE.
- i_clr  in  1  clears results in IDLE; aborts a scan in SCAN.
- i_cnt  in  NUM*W  packed counts; entry k at bits [k*W +: W].
- o_busy  out  1  high in SCAN and DONE.
- o_done  out  1  one-cycle pulse when results update.
- o_valid  out  1  max > 0.
- o_max  out  W  largest count.
- o_idx  out  IDX_W  index of largest count.
- o_sec  out  W  second-largest count (may equal o_max).
- o_sec_idx  out  IDX_W  index of second-largest.
- o_sec_valid  out  1  o_sec > 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; snapshot, counter and all outputs 0.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - i_start=1 -> capture i_cnt into snapshot; clear working max/sec/idx to 0; ptr=0; go to SCAN.
  - If i_start and i_clr arrive together, i_clr wins: no scan starts and results clear.
  - i_clr=1 alone -> clear all result outputs to 0 next cycle; stay IDLE.
- SCAN:
  - Each cycle compares snapshot[ptr] (value v) against working results:
    - v > max -> sec <= max, sec_idx <= idx, max <= v, idx <= ptr.
    - else if v > sec -> sec <= v, sec_idx <= ptr.
    - else no change.
  - Tie rule: lowest index wins max. An equal later entry becomes sec, so margin is 0.
  - ptr == NUM-1 -> go to DONE, ptr <= 0. Exactly NUM compare cycles.
  - i_start is ignored. i_cnt changes have no effect (snapshot is held).
  - i_clr=1 -> abort to IDLE; working and output results cleared; no o_done.
- DONE (one cycle):
  - Copy working results to the output registers; o_done=1.
  - Next state IDLE. i_start and i_clr in DONE are ignored.
- Latency: start sampled at edge 0; o_done high and outputs updated after edge NUM+1. Back-to-back start is possible from IDLE at edge NUM+2.
- Outputs change only in DONE or on clr/reset, and hold between scans.
- All-zero input: o_valid=0, o_sec_valid=0, indices 0.
- NUM not a power of two: ptr never exceeds NUM-1, so unused index codes never occur.

Optional Feature:
- Macro: FIND_TOP2_MARGIN_EN.
- Defined:
  - Extra input i_thr (W bits).
  - Extra output o_margin (W) = o_max - o_sec. Never negative by construction.
  - Extra output o_ambig (1) = o_valid & (o_margin < i_thr).
  - o_margin is registered with the other results at DONE.
  - o_ambig is combinational from o_margin and i_thr.
  - Both are 0 on reset and clr.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package find_top2_pkg holds:
  - state enum {IDLE, SCAN, DONE}.
  - A clog2 helper function for the IDX_W check.
- One sub-module, top2_update: purely combinational. Inputs v, ptr, max, idx, sec, sec_idx; outputs the next values per the compare rule.
- The FSM, snapshot, counter and output registers stay in find_top2.

Test Plan:
- Distinct values: NUM=18, W=7, entry k = k+1 except entry 5 = 100, entry 12 = 90; start -> o_done exactly 19 cycles after the start edge; max=100, idx=5, sec=90, sec_idx=12, valid=1, sec_valid=1.
- Ties and ordering:
  - Entries 3 and 9 = 50, rest 0 -> max=50, idx=3, sec=50, sec_idx=9; with MARGIN_EN and i_thr=1: margin=0, ambig=1.
  - Entry 0 = 10, entry 17 = 127 (last index), rest 0 -> max=127, idx=17, sec=10, sec_idx=0.
- All zeros: start -> o_done pulse; valid=0, sec_valid=0, max=0, idx=0.
- Abort and snapshot hold: start, change i_cnt mid-scan, then i_clr at scan cycle 7 -> no o_done, all outputs 0, state IDLE. Re-start -> results come from the new snapshot only. A start pulsed during SCAN produces no second o_done.
- Reset mid-scan: rst_n low at scan cycle 10 -> all outputs 0 and o_busy=0 immediately (asynchronous). After release, a start with one nonzero entry (entry 4 = 7) -> max=7, idx=4, sec=0, sec_valid=0.
